// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore sequencer for the multi-cycle RV32I datapath
// (lw, sw, R-type, beq). It time-shares one ALU and one memory port across
// fetch, address generation, execute and branch compare, stalls memory
// phases on mem_ready, and counts retired instructions.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       Op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             retire,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        BEQ      = 4'd8
    } state_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // State kept as a plain vector so the unused codes 9-15 stay representable
    // and can be steered back to FETCH.
    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       alu_rtype;
    logic             fetch_go;

    // Only funct7[5] distinguishes add from sub in the supported subset.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // R-type ALU operation from funct3/funct7.
    always_comb begin
        case (funct3)
            3'b000:  alu_rtype = funct7[5] ? 3'b001 : 3'b000;
            3'b010:  alu_rtype = 3'b101;
            3'b110:  alu_rtype = 3'b011;
            3'b111:  alu_rtype = 3'b010;
            3'b100:  alu_rtype = 3'b111;
            default: alu_rtype = 3'b000;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (Op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Next-state and control decode; write strobes are suppressed while rst is high.
    always_comb begin
        state_d    = state_q;
        fetch_go   = mem_ready & run;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = fetch_go;
                IRWrite   = fetch_go;
                if (fetch_go) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTER;
                    OP_BEQ:       state_d = BEQ;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (Op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_rtype;
                state_d    = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                PCWrite    = Zero;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            retire   = 1'b0;
            illegal  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter, wrapping at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign state         = state_q;
    assign retired_count = count_q;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencer for the RV32I subset the golden datapath supports: `lw`, `sw`, R-type (`add`/`sub`/`slt`/`or`/`and`/`xor`) and `beq`. It lets one shared ALU and one unified memory port be time-multiplexed across fetch, address generation, execute and branch compare. It sits beside the multi-cycle datapath and drives its mux selects, write enables and ALUControl, replacing the single-cycle control unit. Memory accesses stall on a ready handshake, and a free-running retired-instruction counter feeds the fault-simulator compare logic.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  allows leaving FETCH; when 0, the block parks in FETCH
- Op  in  7  opcode from the instruction register
- funct3  in  3  instr[14:12] from the instruction register
- funct7  in  7  instr[31:25] from the instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  instruction register and OldPC enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = reg A
- ALUSrcB  out  2  ALU B select: 00 = reg B, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  immediate select: 00 = I, 01 = S, 10 = B, decoded from Op in every state
- ALUControl  out  3  ALU operation code
- retire  out  1  single-cycle pulse when an instruction completes
- illegal  out  1  single-cycle pulse when an unsupported opcode is decoded
- state  out  4  current state encoding, for debug and fault compare
- retired_count  out  CNT_W  count of retired instructions

## Operation
- Moore FSM. The state register is the only state besides retired_count. Outputs decode combinationally from state, plus the gating listed below.
- Any output not listed for a state is 0.
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4
  - MEMWRITE = 5, EXECUTER = 6, ALUWB = 7, BEQ = 8
  - codes 9–15 are unused; an unused code goes to FETCH on the next edge.
- FETCH:
  - AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUControl = 000, ResultSrc = 10.
  - IRWrite = PCWrite = mem_ready & run.
  - Goes to DECODE when mem_ready & run, otherwise holds.
- DECODE:
  - ALUSrcA = 01, ALUSrcB = 01, ALUControl = 000 (computes the branch target into ALUOut).
  - Next state by Op: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 1100011 → BEQ.
  - Any other Op → FETCH with illegal = 1. The instruction is not retired.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUControl = 000. Op 0000011 → MEMREAD, otherwise → MEMWRITE.
- MEMREAD: AdrSrc = 1, ResultSrc = 00. Holds until mem_ready, then → MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, retire = 1, → FETCH.
- MEMWRITE:
  - AdrSrc = 1, ResultSrc = 00, MemWrite = 1 held every cycle until mem_ready.
  - On mem_ready: retire = 1, → FETCH.
- EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUControl from funct decode, → ALUWB.
  - funct3 000 with funct7[5] = 1 → 001
  - funct3 000 with funct7[5] = 0 → 000
  - funct3 010 → 101
  - funct3 110 → 011
  - funct3 111 → 010
  - funct3 100 → 111
  - any other funct3 → 000
- ALUWB: ResultSrc = 00, RegWrite = 1, retire = 1, → FETCH.
- BEQ:
  - ALUSrcA = 10, ALUSrcB = 00, ALUControl = 001, ResultSrc = 00.
  - PCWrite = Zero, retire = 1, → FETCH.
- retired_count increments by 1 on every cycle with retire = 1 and wraps modulo 2^CNT_W.
- run is sampled only in FETCH. Deasserting run mid-instruction does not abort that instruction.

## Timing
- Reset:
  - rst high: state goes to FETCH and retired_count to 0, asynchronously.
  - While rst is high, PCWrite, IRWrite, MemWrite, RegWrite, retire and illegal are forced to 0, regardless of mem_ready and run.
  - Reset mid-instruction abandons the instruction with no write strobes. The first fetch happens on the first edge after rst falls, if mem_ready & run.
- Latency with mem_ready held at 1, FETCH to the return to FETCH:
  - beq: 3 cycles
  - R-type: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - illegal: 2 cycles
- Each cycle with mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- The retire pulse is exactly one cycle, in the final state of the instruction. The counter update is visible the following cycle.
- Op, funct3 and funct7 must be stable from the DECODE cycle through the instruction's last state. The instruction register changes only under IRWrite.

## Test plan
- Reset then R-type `sub` (Op 0110011, funct3 000, funct7 0100000), mem_ready = 1, run = 1 → states 0,1,6,7,0. ALUControl = 001 in EXECUTER. RegWrite only in ALUWB. retired_count = 1.
- `lw` with mem_ready low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0. RegWrite with ResultSrc = 01 in MEMWB. 7 cycles total.
- `sw` with mem_ready low for 1 cycle → MemWrite = 1 and AdrSrc = 1 for 2 consecutive cycles in state 5. retire on the second cycle.
- `beq` run twice, once with Zero = 1 and once with Zero = 0 → PCWrite = 1 in BEQ only for the taken case. Both retire. retired_count increments by 2.
- Op 0010011 decoded → illegal pulses one cycle in DECODE, next state 0, retire stays 0, counter unchanged. Unused state code 12 forced in → FETCH next edge.
- rst raised in MEMWRITE with MemWrite high → MemWrite drops immediately, state = 0, retired_count = 0. With run = 0 after release, the block stays in FETCH with IRWrite = 0.
